// File: rtl/pc_pkg.sv
// Shared constants and types for the program-counter register.
package pc_pkg;

    localparam int PC_WIDTH = 8;
    localparam logic [PC_WIDTH-1:0] PC_RESET = '0;

    typedef logic [PC_WIDTH-1:0] pc_t;

endpackage

// File: rtl/program_counter_if.sv
// Bundles the next-PC / current-PC pair between fetch logic and the PC register.
interface program_counter_if
    import pc_pkg::*;
#(
    parameter int WIDTH = PC_WIDTH
);

    logic [WIDTH-1:0] pc;
    logic [WIDTH-1:0] pc_out;

    // master computes the next PC; slave is the register holding it
    modport master (output pc, input pc_out);
    modport slave (input pc, output pc_out);

endinterface

// File: rtl/program_counter.sv
// Program-counter register: loads the externally computed next PC every rising edge,
// forced asynchronously to RESET_VALUE while rst is high.
module program_counter
    import pc_pkg::*;
#(
    parameter int               WIDTH       = PC_WIDTH,
    parameter logic [WIDTH-1:0] RESET_VALUE = WIDTH'(PC_RESET)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] PC,
    output logic [WIDTH-1:0] PC_out
);

    // NOTE: sequential state uses non-blocking assignment so every flop samples
    // pre-edge values; rst is in the sensitivity list to make it take effect at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            PC_out <= RESET_VALUE;
        end else begin
            PC_out <= PC;
        end
    end

`ifndef SYNTHESIS
    logic seen_reset;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seen_reset <= 1'b1;
        end
    end

    a_reset_value: assert property (@(posedge clk) rst |-> (PC_out == RESET_VALUE))
        else $error("PC_out differs from RESET_VALUE while rst is high");

    a_load_next: assert property (@(posedge clk) disable iff (rst)
        (!rst && seen_reset === 1'b1) |=> (PC_out == $past(PC)))
        else $error("PC_out did not load the PC sampled one edge earlier");

    a_no_x: assert property (@(posedge clk) (seen_reset === 1'b1) |-> !$isunknown(PC_out))
        else $error("PC_out is unknown after reset");
`endif

endmodule

// File: tb/tb_program_counter.sv
// Directed bench for program_counter: default 8-bit instance plus a 12-bit one
// with a non-zero reset vector.
module tb_program_counter;
    import pc_pkg::*;

    logic clk;
    logic rst;
    logic rst12;

    program_counter_if #(.WIDTH(PC_WIDTH)) bus8 ();
    program_counter_if #(.WIDTH(12))       bus12 ();

    program_counter dut8 (
        .clk    (clk),
        .rst    (rst),
        .PC     (bus8.pc),
        .PC_out (bus8.pc_out)
    );

    program_counter #(.WIDTH(12), .RESET_VALUE(12'h100)) dut12 (
        .clk    (clk),
        .rst    (rst12),
        .PC     (bus12.pc),
        .PC_out (bus12.pc_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic after_rise();
        @(posedge clk);
        #1;
    endtask

    pc_t seq_vals[5]  = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    pc_t wrap_vals[3] = '{8'hFE, 8'hFF, 8'h00};

    initial begin
        pc_t prev;

        rst        = 1'b1;
        rst12      = 1'b1;
        bus8.pc    = 8'h00;
        bus12.pc   = 12'h000;
        #1;
        check("async_reset_t0", 32'(bus8.pc_out), 32'h00);
        check("w12_async_reset_t0", 32'(bus12.pc_out), 32'h100);

        // reset held across clock edges with PC driven
        for (int i = 0; i < 3; i++) begin
            after_rise();
            check($sformatf("reset_hold_%0d", i), 32'(bus8.pc_out), 32'h00);
        end
        bus12.pc = 12'hFFF;
        after_rise();
        check("w12_reset_hold", 32'(bus12.pc_out), 32'h100);

        // release both resets on a falling edge
        @(negedge clk);
        rst   = 1'b0;
        rst12 = 1'b0;
        bus12.pc = 12'hABC;
        #1;
        check("w12_before_load", 32'(bus12.pc_out), 32'h100);
        after_rise();
        check("w12_load_abc", 32'(bus12.pc_out), 32'hABC);
        check("first_load_after_reset", 32'(bus8.pc_out), 32'h00);

        // incrementing sequence, one-cycle latency
        prev = 8'h00;
        foreach (seq_vals[i]) begin
            @(negedge clk);
            bus8.pc = seq_vals[i];
            #1;
            check($sformatf("seq_pre_%0d", i), 32'(bus8.pc_out), 32'(prev));
            after_rise();
            check($sformatf("seq_post_%0d", i), 32'(bus8.pc_out), 32'(seq_vals[i]));
            prev = seq_vals[i];
        end

        // full range and wrap pass through unchanged
        foreach (wrap_vals[i]) begin
            @(negedge clk);
            bus8.pc = wrap_vals[i];
            after_rise();
            check($sformatf("wrap_%0d", i), 32'(bus8.pc_out), 32'(wrap_vals[i]));
        end

        // reset raised mid-cycle with PC_out at 0x05
        @(negedge clk);
        bus8.pc = 8'h05;
        after_rise();
        check("pre_reset_value", 32'(bus8.pc_out), 32'h05);
        #2;
        rst = 1'b1;
        #1;
        check("mid_cycle_reset", 32'(bus8.pc_out), 32'h00);
        bus8.pc = 8'h77;
        after_rise();
        check("reset_wins_over_load", 32'(bus8.pc_out), 32'h00);

        @(negedge clk);
        rst     = 1'b0;
        bus8.pc = 8'h33;
        after_rise();
        check("load_after_release", 32'(bus8.pc_out), 32'h33);

        // PC glitching between edges must not reach PC_out
        @(negedge clk);
        bus8.pc = 8'h10;
        #1;
        check("toggle_hold_a", 32'(bus8.pc_out), 32'h33);
        bus8.pc = 8'h20;
        #1;
        bus8.pc = 8'hA5;
        #1;
        check("toggle_hold_b", 32'(bus8.pc_out), 32'h33);
        bus8.pc = 8'h30;
        after_rise();
        check("toggle_edge_value", 32'(bus8.pc_out), 32'h30);
        bus8.pc = 8'hC3;
        #2;
        check("hold_after_edge", 32'(bus8.pc_out), 32'h30);
        after_rise();
        check("next_edge_value", 32'(bus8.pc_out), 32'hC3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/program_counter.md
PROGRAM_COUNTER -- requirements
Module: program_counter

Interface
REQ-001 Parameter WIDTH, default 8, SHALL set the bit width of PC and PC_out.
REQ-002 Parameter RESET_VALUE, default 0 (WIDTH bits), SHALL set the value PC_out takes during reset.
REQ-003 Port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge only.
REQ-004 Port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 Port PC, input, WIDTH bits: next program-counter value, computed externally.
REQ-006 Port PC_out, output, WIDTH bits: registered current program-counter value.
REQ-007 Port order SHALL be clk, rst, PC, PC_out so that positional instantiation connects correctly.
REQ-008 The design SHALL have one clock, and reset SHALL be asynchronous and active-high.

Function
REQ-009 On each rising clk edge with rst low, PC_out SHALL take the value on PC sampled at that edge.
REQ-010 Latency SHALL be exactly one clock edge from PC to PC_out, with no combinational path from PC to PC_out.
REQ-011 PC_out SHALL hold its value between rising edges regardless of PC activity.
REQ-012 The register SHALL load on every rising edge; there is no enable and no hold condition.
REQ-013 The register SHALL perform no arithmetic; incrementing and branching are the caller's job.
REQ-014 The full WIDTH-bit range SHALL pass through unchanged, including all-ones (0xFF at default width) and a wrap from 0xFF to 0x00.
REQ-015 If rst is high at a rising edge, reset SHALL win over the PC load.
REQ-016 After rst deasserts, the first rising edge with rst low SHALL load PC normally.
REQ-017 PC_out SHALL never be X or Z after reset has been applied once.

Reset
REQ-018 Asserting rst SHALL force PC_out to RESET_VALUE immediately, without waiting for a clock edge.
REQ-019 PC_out SHALL stay at RESET_VALUE for as long as rst is high, whatever clk and PC do.
REQ-020 Asserting rst mid-operation SHALL discard the current value with no partial-cycle effects.
REQ-021 Reset deassertion SHALL be synchronized externally; the block adds no reset synchronizer.

Structure
REQ-022 A shared package (pc_pkg) SHALL hold the default width constant PC_WIDTH = 8, the default reset vector PC_RESET = 0, and the typedef pc_t (logic [PC_WIDTH-1:0]).
REQ-023 The block SHALL be a single flat module with no sub-modules; the parameterized register is its only state element.
REQ-024 The block SHALL include embedded assertions, guarded for simulation only:
- PC_out equals RESET_VALUE while rst is high.
- PC_out equals the past value of PC one edge after any edge with rst low.
- No X appears on PC_out after the first reset.

Verification
REQ-025 Test: hold rst=1 with PC=0x00 while clk toggles -> PC_out = 0x00 throughout.
REQ-026 Test: release rst, then drive PC = 0x01, 0x02, 0x03, 0x04, 0x05, one value per cycle, changed on the falling edge -> PC_out shows 0x01 through 0x05, each one cycle after it was applied.
REQ-027 Test: drive PC from 0xFE to 0xFF to 0x00 -> PC_out follows with one-cycle lag and the wrap is passed through unchanged.
REQ-028 Test: with PC_out = 0x05, raise rst between clock edges -> PC_out = 0x00 before the next rising edge.
REQ-029 Test: toggle PC several times between rising edges -> PC_out changes only at the rising edge, to the value present at that edge.
REQ-030 Test: instantiate with WIDTH=12 and RESET_VALUE=0x100, then reset and load 0xABC -> PC_out = 0x100 in reset and 0xABC one cycle after the load.
